// File: rtl/cdp_lut_idx_calc_pkg.sv
// Shared CDP LUT index constants and the per-sample index/fraction record.
// The record travels from the index math into the S1 pipeline stage.
package cdp_lut_idx_calc_pkg;

    localparam int LUT_DEPTH = 65;
    localparam int IDX_W     = 7;
    localparam int FRAC_W    = 16;
    localparam int X_W       = 38;
    localparam int D_W       = 39;
    localparam int ENTRY_W   = 16;
    localparam int N_W       = 5;
    localparam int OSHIFT_W  = 6;
    localparam int Y0_W      = D_W;
    localparam int Y1_W      = X_W;
    localparam int OFLOW_IDX = LUT_DEPTH - 1;
    localparam int Q_W       = $clog2(OFLOW_IDX);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [FRAC_W-1:0] frac;
        logic              uflow;
        logic              oflow;
    } idx_res_t;

    // On either range flag both reads target the clamped entry.
    function automatic logic [IDX_W-1:0] addr1_of(input idx_res_t r);
        return (r.uflow || r.oflow) ? r.idx : r.idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/cdp_lut_idx_math.sv
// Combinational LUT index math: D = X - S, Q = D >> N, with the range clamp and
// the 16 bits just below the index position taken as the fraction.
module cdp_lut_idx_math
    import cdp_lut_idx_calc_pkg::*;
(
    input  logic [X_W-1:0] x,
    input  logic [X_W-1:0] s,
    input  logic [N_W-1:0] n,
    output idx_res_t       res
);

    logic [D_W-1:0] d;
    logic [D_W-1:0] q;

    always_comb begin
        d   = {1'b0, x} - {1'b0, s};
        q   = d >> n;
        res = '0;
        if (d[D_W-1]) begin
            res.uflow = 1'b1;
        end else if (q[D_W-1:Q_W] != '0) begin
            res.oflow = 1'b1;
            res.idx   = IDX_W'(OFLOW_IDX);
        end else begin
            res.idx  = {1'b0, q[Q_W-1:0]};
            // Appending zeros below bit 0 makes N=0 yield a zero fraction.
            res.frac = FRAC_W'({d, {FRAC_W{1'b0}}} >> n);
        end
    end

endmodule

// File: rtl/cdp_lut_idx_calc.sv
// CDP LUT index calculator: S1 holds the computed index and issues the LUT read,
// S2 receives the read data and holds it until the interpolation unit takes it.
module cdp_lut_idx_calc
    import cdp_lut_idx_calc_pkg::*;
(
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic [X_W-1:0]      in_pd,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [X_W-1:0]      cfg_lut_start,
    input  logic [N_W-1:0]      cfg_lut_idx_shift,
    input  logic [OSHIFT_W-1:0] cfg_lut_oflow_shift,
    output logic                lut_rd_en,
    output logic [IDX_W-1:0]    lut_rd_addr0,
    output logic [IDX_W-1:0]    lut_rd_addr1,
    input  logic [ENTRY_W-1:0]  lut_rd_data0,
    input  logic [ENTRY_W-1:0]  lut_rd_data1,
    output logic [Y0_W-1:0]     out_y0,
    output logic [Y1_W-1:0]     out_y1,
    output logic [FRAC_W:0]     out_frac,
    output logic [OSHIFT_W-1:0] out_shift,
    output logic                out_uflow,
    output logic                out_oflow,
    output logic                out_vld,
    input  logic                out_rdy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and a presented sample stays unchanged until taken.

    idx_res_t              math_res;
    logic                  accept;
    logic                  s1_adv;
    logic [ENTRY_W-1:0]    y0_sel;
    logic [ENTRY_W-1:0]    y1_sel;

    logic                  s1_vld_q, s1_vld_d;
    idx_res_t              s1_res_q, s1_res_d;
    logic [OSHIFT_W-1:0]   s1_shift_q, s1_shift_d;
    logic                  s2_vld_q, s2_vld_d;
    logic                  s2_first_q, s2_first_d;
    logic [FRAC_W-1:0]     s2_frac_q, s2_frac_d;
    logic                  s2_uflow_q, s2_uflow_d;
    logic                  s2_oflow_q, s2_oflow_d;
    logic [OSHIFT_W-1:0]   s2_shift_q, s2_shift_d;
    logic [ENTRY_W-1:0]    y0_hold_q, y0_hold_d;
    logic [ENTRY_W-1:0]    y1_hold_q, y1_hold_d;

    cdp_lut_idx_math u_math (
        .x   (in_pd),
        .s   (cfg_lut_start),
        .n   (cfg_lut_idx_shift),
        .res (math_res)
    );

    always_comb begin
        s1_adv       = ~s2_vld_q | out_rdy;
        in_rdy       = ~s1_vld_q | s1_adv;
        accept       = in_vld & in_rdy;
        lut_rd_en    = s1_vld_q & s1_adv;
        lut_rd_addr0 = s1_res_q.idx;
        lut_rd_addr1 = addr1_of(s1_res_q);

        s1_vld_d   = s1_vld_q;
        s1_res_d   = s1_res_q;
        s1_shift_d = s1_shift_q;
        if (s1_adv) begin
            s1_vld_d = 1'b0;
        end
        if (accept) begin
            s1_vld_d   = 1'b1;
            s1_res_d   = math_res;
            s1_shift_d = cfg_lut_oflow_shift;
        end

        s2_vld_d   = s2_vld_q;
        s2_first_d = 1'b0;
        s2_frac_d  = s2_frac_q;
        s2_uflow_d = s2_uflow_q;
        s2_oflow_d = s2_oflow_q;
        s2_shift_d = s2_shift_q;
        if (s1_adv) begin
            s2_vld_d = s1_vld_q;
        end
        if (lut_rd_en) begin
            s2_first_d = 1'b1;
            s2_frac_d  = s1_res_q.frac;
            s2_uflow_d = s1_res_q.uflow;
            s2_oflow_d = s1_res_q.oflow;
            s2_shift_d = s1_shift_q;
        end

        // RAM data is only valid in S2's first cycle, so capture it then.
        y0_hold_d = y0_hold_q;
        y1_hold_d = y1_hold_q;
        if (s2_first_q) begin
            y0_hold_d = lut_rd_data0;
            y1_hold_d = lut_rd_data1;
        end

        y0_sel    = s2_first_q ? lut_rd_data0 : y0_hold_q;
        y1_sel    = s2_first_q ? lut_rd_data1 : y1_hold_q;
        out_vld   = s2_vld_q;
        out_y0    = {{(Y0_W-ENTRY_W){y0_sel[ENTRY_W-1]}}, y0_sel};
        out_y1    = {{(Y1_W-ENTRY_W){y1_sel[ENTRY_W-1]}}, y1_sel};
        out_frac  = {1'b0, s2_frac_q};
        out_shift = s2_shift_q;
        out_uflow = s2_uflow_q;
        out_oflow = s2_oflow_q;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            s1_vld_q   <= 1'b0;
            s1_res_q   <= '0;
            s1_shift_q <= '0;
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_frac_q  <= '0;
            s2_uflow_q <= 1'b0;
            s2_oflow_q <= 1'b0;
            s2_shift_q <= '0;
            y0_hold_q  <= '0;
            y1_hold_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_res_q   <= s1_res_d;
            s1_shift_q <= s1_shift_d;
            s2_vld_q   <= s2_vld_d;
            s2_first_q <= s2_first_d;
            s2_frac_q  <= s2_frac_d;
            s2_uflow_q <= s2_uflow_d;
            s2_oflow_q <= s2_oflow_d;
            s2_shift_q <= s2_shift_d;
            y0_hold_q  <= y0_hold_d;
            y1_hold_q  <= y1_hold_d;
        end
    end

endmodule

// File: tb/tb_cdp_lut_idx_calc.sv
// Bench for cdp_lut_idx_calc: directed corner cases plus randomized traffic checked
// against an arithmetic reference model and a LUT RAM model.
module tb_cdp_lut_idx_calc;

    localparam int EW = 39 + 38 + 17 + 6 + 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [37:0] in_pd;
    logic        in_vld;
    logic        in_rdy;
    logic [37:0] cfg_lut_start;
    logic [4:0]  cfg_lut_idx_shift;
    logic [5:0]  cfg_lut_oflow_shift;
    logic        lut_rd_en;
    logic [6:0]  lut_rd_addr0;
    logic [6:0]  lut_rd_addr1;
    logic [15:0] lut_rd_data0;
    logic [15:0] lut_rd_data1;
    logic [38:0] out_y0;
    logic [37:0] out_y1;
    logic [16:0] out_frac;
    logic [5:0]  out_shift;
    logic        out_uflow;
    logic        out_oflow;
    logic        out_vld;
    logic        out_rdy;

    logic [15:0]   lut_mem [0:64];
    logic [EW-1:0] exp_q [$];
    logic [13:0]   addr_q [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            rdy_mode = 0;
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_obs;

    cdp_lut_idx_calc dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .in_pd               (in_pd),
        .in_vld              (in_vld),
        .in_rdy              (in_rdy),
        .cfg_lut_start       (cfg_lut_start),
        .cfg_lut_idx_shift   (cfg_lut_idx_shift),
        .cfg_lut_oflow_shift (cfg_lut_oflow_shift),
        .lut_rd_en           (lut_rd_en),
        .lut_rd_addr0        (lut_rd_addr0),
        .lut_rd_addr1        (lut_rd_addr1),
        .lut_rd_data0        (lut_rd_data0),
        .lut_rd_data1        (lut_rd_data1),
        .out_y0              (out_y0),
        .out_y1              (out_y1),
        .out_frac            (out_frac),
        .out_shift           (out_shift),
        .out_uflow           (out_uflow),
        .out_oflow           (out_oflow),
        .out_vld             (out_vld),
        .out_rdy             (out_rdy)
    );

    // Clock / reset-free watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] rand38();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    function automatic logic [38:0] sx39(input logic [15:0] v);
        longint t;
        t = $signed(v);
        return t[38:0];
    endfunction

    function automatic logic [37:0] sx38(input logic [15:0] v);
        longint t;
        t = $signed(v);
        return t[37:0];
    endfunction

    // Reference: plain integer arithmetic on D = X - S.
    function automatic void ref_model(input logic [37:0] x, input logic [37:0] s, input logic [4:0] n,
                                      output int idx, output int frac, output bit uf, output bit of);
        longint d;
        longint q;
        d    = $signed({26'd0, x}) - $signed({26'd0, s});
        idx  = 0;
        frac = 0;
        uf   = 1'b0;
        of   = 1'b0;
        if (d < 0) begin
            uf = 1'b1;
        end else begin
            q = d / (longint'(1) << n);
            if (q >= 64) begin
                of  = 1'b1;
                idx = 64;
            end else begin
                idx  = int'(q);
                frac = int'(((d * 65536) / (longint'(1) << n)) % 65536);
            end
        end
    endfunction

    // LUT RAM: data valid one cycle after the read, garbage otherwise.
    always @(posedge clk) begin
        if (lut_rd_en) begin
            lut_rd_data0 <= (lut_rd_addr0 <= 7'd64) ? lut_mem[lut_rd_addr0] : 16'hDEAD;
            lut_rd_data1 <= (lut_rd_addr1 <= 7'd64) ? lut_mem[lut_rd_addr1] : 16'hDEAD;
        end else begin
            lut_rd_data0 <= 16'($urandom());
            lut_rd_data1 <= 16'($urandom());
        end
    end

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = ~out_rdy;
                2:       out_rdy = 1'($urandom_range(0, 1));
                default: out_rdy = 1'b0;
            endcase
        end
    end

    // Scoreboard: model on accept, compare on read issue and on output transfer.
    always @(negedge clk) begin
        logic [EW-1:0] obs;
        logic [EW-1:0] e;
        logic [13:0]   ea;
        int            idx, frac, a1;
        bit            uf, of;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (in_vld && in_rdy) begin
                ref_model(in_pd, cfg_lut_start, cfg_lut_idx_shift, idx, frac, uf, of);
                a1 = (uf || of) ? idx : idx + 1;
                exp_q.push_back({sx39(lut_mem[idx]), sx38(lut_mem[a1]), 17'(frac),
                                 cfg_lut_oflow_shift, uf, of});
                addr_q.push_back({7'(idx), 7'(a1)});
            end
            if (lut_rd_en) begin
                if (addr_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    ea = addr_q.pop_front();
                    check("rd_addr", {lut_rd_addr0, lut_rd_addr1}, ea);
                end
            end
            obs = {out_y0, out_y1, out_frac, out_shift, out_uflow, out_oflow};
            if (prev_stall) check("stall_stable", obs, prev_obs);
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", obs, e);
                end
            end
            prev_stall = out_vld && !out_rdy;
            prev_obs   = obs;
        end
    end

    // Driver: present one sample, hold until accepted, then scramble inputs.
    task automatic push_in(input logic [37:0] x, input logic [37:0] s, input logic [4:0] n,
                           input logic [5:0] sh);
        int budget;
        in_pd               = x;
        cfg_lut_start       = s;
        cfg_lut_idx_shift   = n;
        cfg_lut_oflow_shift = sh;
        in_vld              = 1'b1;
        budget              = 0;
        @(negedge clk);
        while (!in_rdy && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("in_rdy_wait", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld              = 1'b0;
        in_pd               = rand38();
        cfg_lut_start       = rand38();
        cfg_lut_idx_shift   = 5'($urandom());
        cfg_lut_oflow_shift = 6'($urandom());
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Single sample into an empty pipeline with out_rdy high: read at T+1, output at T+2.
    task automatic directed(input string tag, input logic [37:0] x, input logic [37:0] s,
                            input logic [4:0] n, input int e_idx, input int e_a1, input int e_frac,
                            input bit e_uf, input bit e_of);
        logic [5:0] sh;
        sh = 6'($urandom());
        push_in(x, s, n, sh);
        @(negedge clk);
        check({tag, "_rd_en"}, lut_rd_en, 1);
        check({tag, "_addr0"}, lut_rd_addr0, e_idx);
        check({tag, "_addr1"}, lut_rd_addr1, e_a1);
        @(negedge clk);
        check({tag, "_vld"}, out_vld, 1);
        check({tag, "_frac"}, out_frac, e_frac);
        check({tag, "_uflow"}, out_uflow, e_uf);
        check({tag, "_oflow"}, out_oflow, e_of);
        check({tag, "_shift"}, out_shift, sh);
        check({tag, "_y0"}, out_y0, sx39(lut_mem[e_idx]));
        check({tag, "_y1"}, out_y1, sx38(lut_mem[e_a1]));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_out_vld"}, out_vld, 0);
        check({tag, "_rd_en"}, lut_rd_en, 0);
        check({tag, "_y0"}, out_y0, 0);
        check({tag, "_y1"}, out_y1, 0);
        check({tag, "_frac"}, out_frac, 0);
        check({tag, "_shift"}, out_shift, 0);
        check({tag, "_flags"}, {out_uflow, out_oflow}, 0);
    endtask

    initial begin
        logic [37:0] s, x;
        logic [4:0]  n;
        logic [63:0] span, r64;

        for (int i = 0; i < 65; i++) lut_mem[i] = 16'($urandom());
        rstn                = 1'b0;
        in_vld              = 1'b0;
        in_pd               = '0;
        cfg_lut_start       = '0;
        cfg_lut_idx_shift   = '0;
        cfg_lut_oflow_shift = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_in_rdy", in_rdy, 1);
        check_idle_zero("post_rst");
        @(posedge clk);
        #1;

        directed("basic",    38'h35, 38'd0, 5'd4, 3, 4, 16'h5000, 1'b0, 1'b0);
        directed("uflow",    38'd99, 38'd100, 5'd3, 0, 0, 0, 1'b1, 1'b0);
        directed("oflow",    38'd64, 38'd0, 5'd0, 64, 64, 0, 1'b0, 1'b1);
        directed("idx63",    38'd63, 38'd0, 5'd0, 63, 64, 0, 1'b0, 1'b0);
        directed("x_eq_s",   38'd5000, 38'd5000, 5'd7, 0, 1, 0, 1'b0, 1'b0);
        directed("q63_max",  38'd1023, 38'd0, 5'd4, 63, 64, 16'hF000, 1'b0, 1'b0);
        directed("n20",      38'h123 + 38'hABCDE, 38'h123, 5'd20, 0, 1, 16'hABCD, 1'b0, 1'b0);

        // Back-to-back burst against an alternating out_rdy.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            s = rand38() >> 4;
            push_in(s + 38'(i * 37), s, 5'($urandom_range(0, 6)), 6'(i));
        end
        drain();

        // Reset with both stages occupied.
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        push_in(38'd300, 38'd0, 5'd3, 6'd5);
        push_in(38'd10, 38'd20, 5'd2, 6'd6);
        @(negedge clk);
        check("pre_rst_out_vld", out_vld, 1);
        check("pre_rst_in_rdy", in_rdy, 0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_in_rdy", in_rdy, 1);
        check_idle_zero("mid_rst");
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        directed("after_rst", 38'h35, 38'd0, 5'd4, 3, 4, 16'h5000, 1'b0, 1'b0);

        // Randomized traffic with random backpressure and idle gaps.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            s    = rand38() >> $urandom_range(1, 37);
            n    = 5'($urandom_range(0, 31));
            span = 64'd64 << n;
            r64  = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       x = rand38();
                1:       x = s + 38'(r64 % (span + span / 8 + 64'd1));
                2:       x = s - 38'($urandom_range(1, 1000));
                default: x = s;
            endcase
            push_in(x, s, n, 6'($urandom()));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();
        check("addr_q_empty", addr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
